ex_mem: RTL
===========

Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage openMIPS core.
- Latches execute results and HI/LO write requests for one cycle, then presents them to the memory stage.
- Honours the core's 6-bit stall vector: it holds, inserts a bubble, or advances.
- Holds the 64-bit partial result and cycle count that execute needs for two-cycle multiply-accumulate (madd/maddu/msub/msubu), and loops them back to execute.

Parameters:
- DATA_W, 32, general-register / HI / LO width (`RegBus).
- ADDR_W, 5, destination register address width (`RegAddBus).
- STALL_W, 6, stall vector width; bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.

Ports:
- clk  in  1  core clock, rising edge active.
- rst  in  1  asynchronous, active-high reset (`RstEnable = 1'b1).
- stall  in  STALL_W  stall vector from the control block; this block uses stall[3] (ex) and stall[4] (mem).
- ex_wd  in  ADDR_W  execute destination register address.
- ex_wreg  in  1  execute register write enable.
- ex_wdata  in  DATA_W  execute result data.
- ex_whilo  in  1  execute HI/LO write enable.
- ex_hi  in  DATA_W  execute HI value.
- ex_lo  in  DATA_W  execute LO value.
- hilo_i  in  2*DATA_W  multiply-accumulate partial product from execute.
- cnt_i  in  2  multiply-accumulate cycle index from execute.
- mem_wd  out  ADDR_W  registered destination address.
- mem_wreg  out  1  registered register write enable.
- mem_wdata  out  DATA_W  registered result data.
- mem_whilo  out  1  registered HI/LO write enable.
- mem_hi  out  DATA_W  registered HI value.
- mem_lo  out  DATA_W  registered LO value.
- hilo_o  out  2*DATA_W  held partial product, looped back to execute.
- cnt_o  out  2  held cycle index, looped back to execute.

Behaviour:
- All outputs are registers updated on the rising edge of clk. rst asynchronously clears every output to 0 (`ZeroWord, `WriteDisable, 2'b00) with no dependence on clk.
- Latency is exactly one cycle from ex_* to mem_*.
- Each clock edge with rst low takes exactly one of three cases, evaluated in this priority order:
  - ADVANCE: stall[3] = 0.
    - mem_* <= ex_*.
    - hilo_o <= 0, cnt_o <= 0 (accumulate sequence finished or not in use).
  - BUBBLE: stall[3] = 1 and stall[4] = 0.
    - mem_wd, mem_wdata, mem_hi, mem_lo <= 0; mem_wreg, mem_whilo <= 0. This is a NOP, so nothing is written downstream.
    - hilo_o <= hilo_i, cnt_o <= cnt_i. This captures the first-cycle accumulate state so execute can finish in the next cycle.
  - HOLD: stall[3] = 1 and stall[4] = 1.
    - All outputs, including hilo_o and cnt_o, retain their values.
- The case where stall[3] = 0 and stall[4] = 1 is illegal; control never produces it. The block must still treat it as ADVANCE, so stall[3] alone selects advance. The verification bench asserts it never occurs.
- No arithmetic is performed; widths pass through unchanged. hilo_o and cnt_o are plain storage, and cnt wrap-around is execute's concern.
- Asserting reset mid-accumulate (cnt_o = 2'b01) clears hilo_o and cnt_o immediately. On release, execute restarts from cnt = 0.
- A bubble followed by advance in consecutive cycles is the normal two-cycle madd flow:
  - Cycle N: bubble, partial result captured.
  - Cycle N+1: advance, final HI/LO forwarded and hilo_o/cnt_o cleared.
- Consumers of mem_* see the output registers directly, with no combinational bypass.

Decomposition:
- Shared define package (define.v) supplies: RegBus, RegAddBus, DoubleRegBus, RstEnable, WriteEnable, WriteDisable, ZeroWord, Stop/NoStop stall encodings, and a new constant StallBus = 5:0.
- No sub-module. The block is a single flat register file with a three-way next-state select.

Test Plan:
- Reset: assert rst asynchronously between clock edges with all ex_* = 0xFFFFFFFF → every output reads 0 before the next clk edge; outputs stay 0 while rst is held.
- Pass-through: stall = 6'b000000, ex_wd = 5'd7, ex_wreg = 1, ex_wdata = 0x12345678, ex_whilo = 1, ex_hi = 0xAAAA0000, ex_lo = 0x0000BBBB → the same values appear on mem_* after exactly one edge.
- Bubble + capture: stall = 6'b001111, ex_wreg = 1, ex_wdata = 0xDEADBEEF, hilo_i = 0x00000001_00000002, cnt_i = 1 → mem_wreg = 0, mem_wdata = 0, mem_whilo = 0; hilo_o = 0x00000001_00000002, cnt_o = 1.
- madd two-cycle flow: the bubble-and-capture cycle above, followed by stall = 0 with ex_whilo = 1, ex_hi = 0x3, ex_lo = 0x4 → mem_hi = 3, mem_lo = 4, mem_whilo = 1; hilo_o = 0 and cnt_o = 0 on the same edge.
- Hold: load mem_wdata = 0x55AA55AA, then apply stall = 6'b011111 for 3 cycles with ex_wdata changing every cycle → mem_wdata stays 0x55AA55AA, and hilo_o/cnt_o are unchanged throughout.
- Reset mid-accumulate: hilo_o = 0x1_0000_0000 and cnt_o = 1, then assert rst → both clear immediately; after release with stall = 0, the first edge forwards the new ex_* values.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared core constants and the stall-driven step select for the EX/MEM register.
package ex_mem_pkg;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STALL_BUS  = 6;
  localparam int STALL_EX   = 3;
  localparam int STALL_MEM  = 4;
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  typedef enum logic [1:0] {ADVANCE, BUBBLE, HOLD} step_e;
  function automatic step_e step_sel(input logic ex_stall, input logic mem_stall);
    return ex_stall == NO_STOP ? ADVANCE : mem_stall == NO_STOP ? BUBBLE : HOLD;
  endfunction
endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with stall/bubble handling and madd partial-result loopback.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = REG_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int STALL_W = STALL_BUS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);
  step_e step;
  logic  unused_stall;
  assign step = step_sel(stall[STALL_EX], stall[STALL_MEM]);
  assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};
  // A bubble still latches the accumulate state so execute can finish madd next cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst == RST_ENABLE) begin
      mem_wd    <= '0;
      mem_wreg  <= WRITE_DISABLE;
      mem_wdata <= '0;
      mem_whilo <= WRITE_DISABLE;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= '0;
      cnt_o     <= 2'b00;
    end else if (step == ADVANCE) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_whilo <= ex_whilo;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      hilo_o    <= '0;
      cnt_o     <= 2'b00;
    end else if (step == BUBBLE) begin
      mem_wd    <= '0;
      mem_wreg  <= WRITE_DISABLE;
      mem_wdata <= '0;
      mem_whilo <= WRITE_DISABLE;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
endmodule
